// File: rtl/btn_conditioner.sv
// Button front end: two-flop synchronizer, per-channel debounce, registered
// press/release pulses and a saturating count of accepted presses.
module btn_conditioner #(
  parameter int N_BTN           = 8,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             en,
  input  logic             count_clr,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_press,
  output logic [CNT_W-1:0] press_count
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int POP_W = $clog2(N_BTN + 1);
  localparam int SUM_W = CNT_W + POP_W;
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  function automatic logic [POP_W-1:0] popcount(input logic [N_BTN-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < N_BTN; i++) n = n + POP_W'(v[i]);
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [POP_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > CNT_MAX) return {CNT_W{1'b1}};
    return s[CNT_W-1:0];
  endfunction

  logic [N_BTN-1:0] r_sync_p0, r_sync_p1;
  logic [N_BTN-1:0] r_level, r_press, r_release;
  logic [DB_W-1:0]  r_cnt [N_BTN];
  logic             r_any;
  logic [CNT_W-1:0] r_count;
  logic [N_BTN-1:0] w_accept, w_rise, w_fall;

  // Stage p0/p1: metastability guard on the asynchronous pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
    end else begin
      r_sync_p0 <= btn_raw;
      r_sync_p1 <= r_sync_p0;
    end
  end

  always_comb begin
    w_accept = '0;
    for (int i = 0; i < N_BTN; i++)
      w_accept[i] = (r_sync_p1[i] != r_level[i]) && (r_cnt[i] == DB_LAST);
  end
  assign w_rise = w_accept & r_sync_p1;
  assign w_fall = w_accept & ~r_sync_p1;

  // Debounce stage: level and edge pulses all update on the acceptance edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_any     <= 1'b0;
      for (int i = 0; i < N_BTN; i++) r_cnt[i] <= '0;
    end else begin
      r_press   <= w_rise & {N_BTN{en}};
      r_release <= w_fall & {N_BTN{en}};
      r_any     <= en & (|w_rise);
      for (int i = 0; i < N_BTN; i++) begin
        if (r_sync_p1[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_cnt[i]   <= '0;
          r_level[i] <= r_sync_p1[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Count stage: one cycle behind the press pulses; clear wins over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_count <= '0;
    else if (count_clr) r_count <= '0;
    else                r_count <= sat_add(r_count, popcount(r_press));
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;
  assign any_press   = r_any;
  assign press_count = r_count;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with a 4-cycle debounce window.
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] btn_raw;
  logic       en;
  logic       count_clr;
  logic [7:0] btn_level, btn_press, btn_release, press_count;
  logic       any_press;

  int total = 0;
  int bad   = 0;

  btn_conditioner #(.N_BTN(8), .DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .en(en), .count_clr(count_clr),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .any_press(any_press), .press_count(press_count)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; btn_raw = 8'hFF; en = 1'b1; count_clr = 1'b0;
    step(2);
    chk("rst_level", btn_level, 8'h00);
    chk("rst_press", btn_press, 8'h00);
    chk("rst_release", btn_release, 8'h00);
    chk("rst_any", any_press, 1'b0);
    chk("rst_count", press_count, 8'd0);

    // Held buttons through reset are accepted after the full latency
    rst = 1'b0;
    step(5);
    chk("held_e5_level", btn_level, 8'h00);
    step(1);
    chk("held_e6_level", btn_level, 8'hFF);
    chk("held_e6_press", btn_press, 8'hFF);
    chk("held_e6_any", any_press, 1'b1);
    step(1);
    chk("held_e7_press", btn_press, 8'h00);
    chk("held_e7_any", any_press, 1'b0);
    chk("held_e7_count", press_count, 8'd8);

    btn_raw = 8'h00;
    step(6);
    chk("relall_release", btn_release, 8'hFF);
    chk("relall_level", btn_level, 8'h00);
    chk("relall_press", btn_press, 8'h00);
    step(1);
    chk("relall_release_off", btn_release, 8'h00);
    chk("relall_count", press_count, 8'd8);
    count_clr = 1'b1;
    step(1);
    count_clr = 1'b0;
    chk("clr_count", press_count, 8'd0);

    // Clean press and release on channel 3
    btn_raw = 8'h08;
    step(5);
    chk("p3_e5_level", btn_level, 8'h00);
    chk("p3_e5_press", btn_press, 8'h00);
    step(1);
    chk("p3_e6_level", btn_level, 8'h08);
    chk("p3_e6_press", btn_press, 8'h08);
    chk("p3_e6_any", any_press, 1'b1);
    step(1);
    chk("p3_e7_press", btn_press, 8'h00);
    chk("p3_e7_count", press_count, 8'd1);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("p3_hold_press", btn_press, 8'h00);
    end
    btn_raw = 8'h00;
    step(5);
    chk("r3_e5_release", btn_release, 8'h00);
    step(1);
    chk("r3_e6_release", btn_release, 8'h08);
    chk("r3_e6_level", btn_level, 8'h00);
    step(1);
    chk("r3_e7_release", btn_release, 8'h00);
    chk("r3_count", press_count, 8'd1);

    // Bounce on channel 5 then a steady rise
    btn_raw = 8'h20; step(1);
    btn_raw = 8'h00; step(1);
    btn_raw = 8'h20; step(1);
    btn_raw = 8'h00; step(1);
    chk("b5_toggle_level", btn_level, 8'h00);
    btn_raw = 8'h20;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("b5_wait_press", btn_press, 8'h00);
      chk("b5_wait_level", btn_level, 8'h00);
    end
    step(1);
    chk("b5_press", btn_press, 8'h20);
    step(1);
    chk("b5_press_off", btn_press, 8'h00);
    chk("b5_count", press_count, 8'd2);
    btn_raw = 8'h00;
    step(7);

    // Three-cycle glitch on idle channel 1
    btn_raw = 8'h02;
    step(3);
    btn_raw = 8'h00;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("g1_level", btn_level, 8'h00);
      chk("g1_press", btn_press, 8'h00);
      chk("g1_release", btn_release, 8'h00);
    end

    // Simultaneous channels 0 and 7, then the same with pulses disabled
    btn_raw = 8'h81;
    step(6);
    chk("s81_press", btn_press, 8'h81);
    chk("s81_any", any_press, 1'b1);
    step(1);
    chk("s81_press_off", btn_press, 8'h00);
    chk("s81_count", press_count, 8'd4);
    btn_raw = 8'h00;
    step(7);
    en = 1'b0;
    btn_raw = 8'h81;
    step(6);
    chk("en0_level", btn_level, 8'h81);
    chk("en0_press", btn_press, 8'h00);
    chk("en0_any", any_press, 1'b0);
    step(1);
    chk("en0_count", press_count, 8'd4);
    chk("en0_press_late", btn_press, 8'h00);
    en = 1'b1;
    btn_raw = 8'h00;
    step(7);

    // Saturation: 31*8 = 248, then 256 clamps to 255, then 4 more hold at 255
    count_clr = 1'b1;
    step(1);
    count_clr = 1'b0;
    for (int r = 0; r < 31; r++) begin
      btn_raw = 8'hFF; step(7);
      btn_raw = 8'h00; step(7);
    end
    chk("sat_248", press_count, 8'd248);
    btn_raw = 8'hFF; step(7);
    chk("sat_255", press_count, 8'd255);
    btn_raw = 8'h00; step(7);
    btn_raw = 8'h0F; step(7);
    chk("sat_hold", press_count, 8'd255);
    btn_raw = 8'h00; step(7);

    // Clear in the same cycle the increment would land
    btn_raw = 8'h10;
    step(6);
    chk("clr_press", btn_press, 8'h10);
    count_clr = 1'b1;
    step(1);
    count_clr = 1'b0;
    chk("clr_prio", press_count, 8'd0);
    step(1);
    chk("clr_after", press_count, 8'd0);
    btn_raw = 8'h00;
    step(7);

    // Reset while channel 2 is part way through its count
    btn_raw = 8'h01;
    step(7);
    chk("pre_rst_level", btn_level, 8'h01);
    chk("pre_rst_count", press_count, 8'd1);
    btn_raw = 8'h05;
    step(4);
    rst = 1'b1;
    #2;
    chk("mid_rst_level", btn_level, 8'h00);
    chk("mid_rst_count", press_count, 8'd0);
    chk("mid_rst_press", btn_press, 8'h00);
    chk("mid_rst_any", any_press, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(5);
    chk("post_rst_e5_level", btn_level, 8'h00);
    step(1);
    chk("post_rst_e6_level", btn_level, 8'h05);
    chk("post_rst_e6_press", btn_press, 8'h05);
    step(1);
    chk("post_rst_count", press_count, 8'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
